ysyx_220053_trap_ctrl: RTL and testbench
========================================

# ysyx_220053_trap_ctrl

Trap sequencer for the ysyx_220053 core. It sits between the commit stage and the CSR file, and is the initiator side of the CSR trap interface. It detects ecall, mret and machine-timer interrupts at instruction retirement and drives the CSR file's `Ecall`/`Mret`/`epc_in` strobes. It then issues a PC redirect to fetch, computed from the CSR file's `mtvec_o`/`mepc_o`, and holds it with a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `CNT_W`, 32, width of trap counter

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `cmt_valid`  in  1  an instruction is retiring this cycle
- `cmt_ecall`  in  1  retiring instruction is ecall (qualified by `cmt_valid`)
- `cmt_mret`  in  1  retiring instruction is mret (qualified by `cmt_valid`)
- `cmt_pc`  in  XLEN  PC of the retiring instruction
- `irq_timer`  in  1  level machine-timer interrupt request
- `mstatus_mie`  in  1  mstatus.MIE from CSR file
- `mtvec_i`  in  XLEN  from CSR `mtvec_o`
- `mepc_i`  in  XLEN  from CSR `mepc_o`
- `ecall_o`  out  1  to CSR `Ecall`; one-cycle pulse
- `mret_o`  out  1  to CSR `Mret`; one-cycle pulse
- `epc_o`  out  XLEN  to CSR `epc_in`
- `cause_o`  out  XLEN  trap cause for mcause
- `cmt_kill`  out  1  combinational; squash the retiring instruction this cycle
- `flush_o`  out  1  one-cycle pipeline flush pulse
- `trap_busy`  out  1  stall upstream; commit inputs are ignored while high
- `redir_valid`  out  1  redirect request to fetch
- `redir_pc`  out  XLEN  redirect target
- `redir_ready`  in  1  fetch accepts redirect
- `trap_cnt`  out  CNT_W  count of traps taken (ecall + interrupt), wraps

## Operation
- FSM states: IDLE, SAVE, REDIR.
- Event detection in IDLE, only when `cmt_valid`=1. Priority order:
  - interrupt: `irq_timer & mstatus_mie`
  - ecall: `cmt_ecall`
  - mret: `cmt_mret`
- Interrupt:
  - `cmt_kill`=1 combinationally; the instruction does not retire.
  - `epc_o` <= `cmt_pc`.
  - `cause_o` <= 0x8000_0000_0000_0007.
- Ecall:
  - `epc_o` <= `cmt_pc`.
  - `cause_o` <= 0xb.
  - `cmt_kill`=0.
- Mret: `epc_o` and `cause_o` hold their previous values.
- Any event: IDLE -> SAVE, and the event kind is latched.
- SAVE (exactly one cycle):
  - `ecall_o`=1 for interrupt or ecall; `mret_o`=1 for mret; never both.
  - `flush_o`=1, `trap_busy`=1.
  - `trap_cnt` increments at the end of SAVE for interrupt or ecall.
  - Next state: REDIR.
- REDIR:
  - `redir_valid`=1, `trap_busy`=1.
  - `redir_pc` is recomputed every cycle from the live CSR inputs, so it always reflects the CSR write made in SAVE.
  - On `redir_valid & redir_ready` the FSM goes to IDLE at the next edge.
- Redirect target arithmetic:
  - mret: `mepc_i`.
  - base = {`mtvec_i[63:2]`, 2'b00}.
  - `mtvec_i[1:0]`==01 and interrupt: base + (cause_o[5:0] << 2), i.e. base + 0x1c for timer.
  - Otherwise: base. Mode values 10/11 are treated as direct.
  - Additions are 64-bit and wrap modulo 2^64.
- `irq_timer` is sampled only in IDLE. An interrupt pending during SAVE/REDIR is taken at the first qualifying commit after return to IDLE.
- `cmt_ecall` and `cmt_mret` both high: treated as ecall.

## Timing
- Reset (async, immediate):
  - state = IDLE.
  - All outputs = 0, including `epc_o`, `cause_o`, `redir_pc` and `trap_cnt`.
  - Reset asserted in SAVE/REDIR drops `redir_valid` and the strobes in the same cycle; no pulse is emitted after reset release.
- Event commit at cycle T:
  - `cmt_kill` (interrupt only) in T.
  - T+1: SAVE; strobe and `flush_o`.
  - T+2: first cycle of `redir_valid`.
- Minimum trap latency: 3 cycles, IDLE back to IDLE, with `redir_ready` tied high.
- `redir_valid` never drops without a handshake. `redir_pc` may change while held only if `mtvec_i`/`mepc_i` change.
- `trap_busy` is high in SAVE and REDIR, low in IDLE. A new event is detectable in the cycle after the handshake.

## Test plan
- Ecall: `cmt_pc`=0x8000_0010, mtvec=0x8000_1000 -> T+1 `ecall_o`=1, `epc_o`=0x8000_0010, `cause_o`=0xb; T+2 `redir_pc`=0x8000_1000; `trap_cnt`=1.
- Mret: mepc=0x8000_0014, `redir_ready` held low 3 cycles -> `mret_o` pulses once; `redir_valid` stays high 4 cycles with `redir_pc`=0x8000_0014; `trap_cnt` unchanged.
- Vectored interrupt: `irq_timer`=1, MIE=1, mtvec=0x8000_2001, `cmt_pc`=0x8000_0100 -> `cmt_kill`=1 at T; `cause_o`=0x8000_0000_0000_0007; `redir_pc`=0x8000_201c.
- Masked or simultaneous events:
  - `irq_timer`=1 with MIE=0 plus ecall -> ecall path taken.
  - `irq_timer`=1 with MIE=1 plus ecall -> interrupt path taken.
  - `cmt_valid` pulses during REDIR -> ignored.
- Async reset asserted in REDIR -> `redir_valid`=0 immediately, `trap_cnt`=0; after release, no strobes until a new event.

Source files
------------

// File: rtl/ysyx_220053_trap_ctrl.sv
// Trap sequencer: turns ecall, mret and timer interrupts at commit into CSR strobes and a fetch redirect.
// Latency: event commit at T, CSR strobe and flush at T+1, redirect valid from T+2; 3 cycles minimum IDLE to IDLE.
// Backpressure: redirect is held until redir_ready; trap_busy stalls upstream and commit inputs are ignored meanwhile.
module ysyx_220053_trap_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmt_valid,
    input  logic             cmt_ecall,
    input  logic             cmt_mret,
    input  logic [XLEN-1:0]  cmt_pc,
    input  logic             irq_timer,
    input  logic             mstatus_mie,
    input  logic [XLEN-1:0]  mtvec_i,
    input  logic [XLEN-1:0]  mepc_i,
    output logic             ecall_o,
    output logic             mret_o,
    output logic [XLEN-1:0]  epc_o,
    output logic [XLEN-1:0]  cause_o,
    output logic             cmt_kill,
    output logic             flush_o,
    output logic             trap_busy,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        REDIR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_IRQ   = 2'd1,
        EV_ECALL = 2'd2,
        EV_MRET  = 2'd3
    } ev_e;

    // Machine timer interrupt: interrupt bit set, exception code 7.
    localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, {(XLEN-4){1'b0}}, 3'b111};
    localparam logic [XLEN-1:0] CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'hb};

    state_e           state_q, state_d;
    ev_e              kind_q, kind_d;
    ev_e              ev;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [XLEN-1:0]  cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  tvec_base;
    logic [XLEN-1:0]  tvec_off;
    logic [XLEN-1:0]  target;

    // Classify the retiring instruction; only looked at in IDLE, interrupt wins over ecall over mret.
    always_comb begin
        ev = EV_NONE;
        if (state_q == IDLE && cmt_valid) begin
            if (irq_timer && mstatus_mie) begin
                ev = EV_IRQ;
            end else if (cmt_ecall) begin
                ev = EV_ECALL;
            end else if (cmt_mret) begin
                ev = EV_MRET;
            end
        end
    end

    // Next-state, latched event kind, trap CSR values and trap counter.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ev != EV_NONE) begin
                    state_d = SAVE;
                    kind_d  = ev;
                end
                if (ev == EV_IRQ) begin
                    epc_d   = cmt_pc;
                    cause_d = CAUSE_IRQ;
                end else if (ev == EV_ECALL) begin
                    epc_d   = cmt_pc;
                    cause_d = CAUSE_ECALL;
                end
            end
            SAVE: begin
                state_d = REDIR;
                if (kind_q == EV_IRQ || kind_q == EV_ECALL) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REDIR: begin
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so no strobe survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= EV_NONE;
            epc_q   <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect target from live CSR values so the SAVE-cycle CSR write is always reflected.
    always_comb begin
        tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
        tvec_off  = {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
        target    = tvec_base;
        if (kind_q == EV_MRET) begin
            target = mepc_i;
        end else if (kind_q == EV_IRQ && mtvec_i[1:0] == 2'b01) begin
            target = tvec_base + tvec_off;
        end
    end

    assign cmt_kill    = ~rst & (ev == EV_IRQ);
    assign ecall_o     = (state_q == SAVE) && (kind_q == EV_IRQ || kind_q == EV_ECALL);
    assign mret_o      = (state_q == SAVE) && (kind_q == EV_MRET);
    assign flush_o     = (state_q == SAVE);
    assign trap_busy   = (state_q != IDLE);
    assign redir_valid = (state_q == REDIR);
    assign redir_pc    = (state_q == REDIR) ? target : '0;
    assign epc_o       = epc_q;
    assign cause_o     = cause_q;
    assign trap_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_220053_trap_ctrl.sv
// Bench for the trap sequencer: directed vector table, corner sequences, random traffic vs a reference model.
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
// Redirect backpressure is exercised with stalls of up to three cycles.
module tb_ysyx_220053_trap_ctrl;

    localparam logic [63:0] C_IRQ = 64'h8000_0000_0000_0007;
    localparam logic [63:0] C_EC  = 64'h0000_0000_0000_000b;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid, cmt_ecall, cmt_mret;
    logic [63:0] cmt_pc;
    logic        irq_timer, mstatus_mie;
    logic [63:0] mtvec_i, mepc_i;
    logic        ecall_o, mret_o, cmt_kill, flush_o, trap_busy, redir_valid, redir_ready;
    logic [63:0] epc_o, cause_o, redir_pc;
    logic [31:0] trap_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    ysyx_220053_trap_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmt_valid(cmt_valid), .cmt_ecall(cmt_ecall), .cmt_mret(cmt_mret), .cmt_pc(cmt_pc),
        .irq_timer(irq_timer), .mstatus_mie(mstatus_mie),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .ecall_o(ecall_o), .mret_o(mret_o), .epc_o(epc_o), .cause_o(cause_o),
        .cmt_kill(cmt_kill), .flush_o(flush_o), .trap_busy(trap_busy),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 none, 1 interrupt, 2 ecall, 3 mret
    typedef struct {
        logic        vld, irq, mie, ec, mr;
        logic [63:0] pc, mtvec, mepc;
        int          kind;
        logic [63:0] epc, cause, rpc;
        logic [31:0] cnt;
        int          delay;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference redirect target, from the architectural rules.
    function automatic logic [63:0] ref_target(input int kind, input logic [63:0] mtvec,
                                               input logic [63:0] mepc, input logic [63:0] cause);
        logic [63:0] base;
        if (kind == 3) return mepc;
        base = mtvec - (mtvec % 4);
        if (kind == 1 && (mtvec % 4) == 1) return base + (cause % 64) * 4;
        return base;
    endfunction

    // Entered 1ns after a rising edge with the DUT idle; leaves at the same phase, DUT idle again.
    task automatic run_txn(input vec_t v, input bit wiggle);
        logic [63:0] exp_pc;
        cmt_valid = v.vld; irq_timer = v.irq; mstatus_mie = v.mie;
        cmt_ecall = v.ec;  cmt_mret = v.mr;   cmt_pc = v.pc;
        mtvec_i = v.mtvec; mepc_i = v.mepc;   redir_ready = 1'b0;
        @(negedge clk);
        chk("kill", cmt_kill, 64'(v.kind == 1));
        chk("idle_busy", trap_busy, 64'd0);
        @(posedge clk); #1;
        cmt_valid = 1'b0; cmt_ecall = 1'b0; cmt_mret = 1'b0;
        if (v.kind == 0) begin
            @(negedge clk);
            chk("none_busy", trap_busy, 64'd0);
            chk("none_flush", flush_o, 64'd0);
            chk("none_cnt", trap_cnt, v.cnt);
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        chk("save_ecall", ecall_o, 64'(v.kind == 1 || v.kind == 2));
        chk("save_mret", mret_o, 64'(v.kind == 3));
        chk("save_flush", flush_o, 64'd1);
        chk("save_busy", trap_busy, 64'd1);
        chk("save_rvld", redir_valid, 64'd0);
        chk("epc", epc_o, v.epc);
        chk("cause", cause_o, v.cause);
        @(posedge clk); #1;
        for (int i = 0; i <= v.delay; i++) begin
            redir_ready = (i == v.delay);
            exp_pc = v.rpc;
            if (wiggle) begin
                mtvec_i = rnd64();
                mepc_i  = rnd64();
                exp_pc  = ref_target(v.kind, mtvec_i, mepc_i, v.cause);
            end
            @(negedge clk);
            chk("redir_valid", redir_valid, 64'd1);
            chk("redir_pc", redir_pc, exp_pc);
            chk("redir_busy", trap_busy, 64'd1);
            chk("redir_strobes", {flush_o, ecall_o, mret_o}, 64'd0);
            @(posedge clk); #1;
        end
        redir_ready = 1'b0;
        @(negedge clk);
        chk("back_idle", trap_busy, 64'd0);
        chk("trap_cnt", trap_cnt, v.cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        v;
        logic [63:0] m_epc, m_cause;
        logic [31:0] m_cnt;

        //        vld  irq  mie  ec   mr   pc                   mtvec                  mepc                  kind epc                 cause  rpc                   cnt delay
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 64'h8000_0010,        64'h8000_1000,         64'h0,                2, 64'h8000_0010,     C_EC,  64'h8000_1000,        1, 0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 64'h9999,             64'h8000_1000,         64'h8000_0014,        3, 64'h8000_0010,     C_EC,  64'h8000_0014,        1, 3};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0100,        64'h8000_2001,         64'h0,                1, 64'h8000_0100,     C_IRQ, 64'h8000_201c,        2, 0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 64'h8000_0200,        64'h8000_2001,         64'h0,                2, 64'h8000_0200,     C_EC,  64'h8000_2000,        3, 1};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 64'h8000_0300,        64'h8000_3001,         64'h0,                1, 64'h8000_0300,     C_IRQ, 64'h8000_301c,        4, 0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 64'h8000_0400,        64'h8000_4003,         64'h0,                2, 64'h8000_0400,     C_EC,  64'h8000_4000,        5, 0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0500,        64'h8000_5002,         64'h0,                1, 64'h8000_0500,     C_IRQ, 64'h8000_5000,        6, 2};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0600,        64'hffff_ffff_ffff_fff1, 64'h0,              1, 64'h8000_0600,     C_IRQ, 64'h0000_0000_0000_000c, 7, 0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0700,        64'h8000_1000,         64'h0,                0, 64'h0,             64'h0, 64'h0,                7, 0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 64'h8000_0800,        64'h8000_1000,         64'h0,                0, 64'h0,             64'h0, 64'h0,                7, 0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 64'h8000_0900,        64'h8000_1001,         64'h0000_1234,        3, 64'h8000_0600,     C_IRQ, 64'h0000_1234,        7, 1};

        // Reset with live-looking inputs: every output must be zero.
        rst = 1'b1; cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_mret = 1'b0; cmt_pc = 64'h8000_0000;
        irq_timer = 1'b1; mstatus_mie = 1'b1; mtvec_i = 64'h8000_1001; mepc_i = 64'h8000_0004;
        redir_ready = 1'b1;
        #3;
        chk("rst_kill", cmt_kill, 64'd0);
        chk("rst_strobes", {ecall_o, mret_o, flush_o, trap_busy, redir_valid}, 64'd0);
        chk("rst_epc", epc_o, 64'd0);
        chk("rst_cause", cause_o, 64'd0);
        chk("rst_redir_pc", redir_pc, 64'd0);
        chk("rst_cnt", trap_cnt, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; cmt_valid = 1'b0; cmt_ecall = 1'b0; irq_timer = 1'b0; mstatus_mie = 1'b0;
        redir_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_txn(tbl[i], 1'b0);

        // Commit during REDIR must be ignored; the interrupt raised there stays pending.
        cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 64'h8000_0a00; mtvec_i = 64'h8000_6000;
        @(posedge clk); #1;
        cmt_valid = 1'b0; cmt_ecall = 1'b0;
        @(posedge clk); #1;
        cmt_valid = 1'b1; cmt_ecall = 1'b1; irq_timer = 1'b1; mstatus_mie = 1'b1;
        @(negedge clk);
        chk("ign_kill", cmt_kill, 64'd0);
        chk("ign_rvld", redir_valid, 64'd1);
        @(posedge clk); #1;
        cmt_valid = 1'b0; cmt_ecall = 1'b0;
        @(negedge clk);
        chk("ign_strobes", {flush_o, ecall_o, mret_o}, 64'd0);
        chk("ign_epc", epc_o, 64'h8000_0a00);
        @(posedge clk); #1;
        redir_ready = 1'b1;
        @(negedge clk);
        chk("ign_rpc", redir_pc, 64'h8000_6000);
        @(posedge clk); #1;
        redir_ready = 1'b0;
        @(negedge clk);
        chk("ign_idle", trap_busy, 64'd0);
        chk("ign_cnt", trap_cnt, 64'd8);
        @(posedge clk); #1;
        v = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0b00, 64'h8000_6000, 64'h0, 1, 64'h8000_0b00, C_IRQ, 64'h8000_6000, 9, 0};
        run_txn(v, 1'b0);

        // Async reset while the redirect is pending.
        irq_timer = 1'b0; mstatus_mie = 1'b0;
        cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 64'h8000_0c00;
        @(posedge clk); #1;
        cmt_valid = 1'b0; cmt_ecall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_rvld", redir_valid, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rvld", redir_valid, 64'd0);
        chk("arst_cnt", trap_cnt, 64'd0);
        chk("arst_busy", trap_busy, 64'd0);
        chk("arst_epc", epc_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {ecall_o, mret_o, flush_o, trap_busy, redir_valid}, 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic against the reference model.
        m_epc = '0; m_cause = '0; m_cnt = '0;
        for (int n = 0; n < 150; n++) begin
            v.vld = ($urandom % 4) != 0;
            v.irq = $urandom % 2; v.mie = $urandom % 2;
            v.ec  = $urandom % 2; v.mr  = $urandom % 2;
            v.pc  = rnd64(); v.mtvec = rnd64(); v.mepc = rnd64();
            v.delay = $urandom % 4;
            if (!v.vld) v.kind = 0;
            else if (v.irq && v.mie) v.kind = 1;
            else if (v.ec) v.kind = 2;
            else if (v.mr) v.kind = 3;
            else v.kind = 0;
            if (v.kind == 1) begin m_epc = v.pc; m_cause = C_IRQ; m_cnt++; end
            if (v.kind == 2) begin m_epc = v.pc; m_cause = C_EC;  m_cnt++; end
            v.epc = m_epc; v.cause = m_cause; v.cnt = m_cnt;
            v.rpc = ref_target(v.kind, v.mtvec, v.mepc, m_cause);
            run_txn(v, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
